// File: rtl/regfile_pkg.sv
// Shared definitions for the register bank with busy scoreboard.
// Provides default sizing, the address-width helper, the packed read-port
// slice helper and the per-register busy-bit update operation type.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned NREAD_DEF = 2;

  // Next-state action for one scoreboard bit in a given cycle.
  typedef enum logic [1:0] {
    BUSY_HOLD  = 2'd0,
    BUSY_CLEAR = 2'd1,
    BUSY_SET   = 2'd2
  } busy_op_e;

  // Address width for a register count; at least one bit.
  function automatic int unsigned calc_aw(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // LSB of field k in a packed bus of fields each w bits wide.
  function automatic int unsigned port_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_bits.sv
// Busy-bit array: one bit per architectural register marking an in-flight
// write. Reservations set bits, writebacks clear them; a reservation and a
// writeback to the same register in one cycle leave the bit set, since the
// reservation belongs to the younger instruction.
// Ports:
//   clk, rst     - clock, synchronous active-high reset (clears all bits)
//   wr_en_i      - writeback enable
//   rd_addr_i    - writeback destination
//   rsv_en_i     - reservation request
//   rsv_addr_i   - register to reserve
//   rsv_ready_o  - reservation would be accepted this cycle
//   busy_vec_o   - full scoreboard
module regfile_scoreboard_bits
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = calc_aw(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  input  logic             rsv_en_i,
  input  logic [AW-1:0]    rsv_addr_i,
  output logic             rsv_ready_o,
  output logic [NREGS-1:0] busy_vec_o
);

  logic [NREGS-1:0] busy_q;
  busy_op_e         busy_op [NREGS];
  logic             wr_zero;
  logic             rsv_zero;
  logic             wr_bypass;
  logic             rsv_accept;

  always_comb begin
    wr_zero   = (ZERO_REG != 0) && (rd_addr_i == '0);
    rsv_zero  = (ZERO_REG != 0) && (rsv_addr_i == '0);
    // A same-cycle writeback retires the pending write, so a new
    // reservation to that register need not wait for the bit to drop.
    wr_bypass = (BYPASS != 0) && wr_en_i && (rd_addr_i == rsv_addr_i);
    rsv_ready_o = rsv_zero | ~busy_q[rsv_addr_i] | wr_bypass;
    rsv_accept  = rsv_en_i && rsv_ready_o && !rsv_zero;
  end

  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      busy_op[i] = BUSY_HOLD;
      if (rsv_accept && (rsv_addr_i == AW'(i)))
        busy_op[i] = BUSY_SET;
      else if (wr_en_i && !wr_zero && (rd_addr_i == AW'(i)))
        busy_op[i] = BUSY_CLEAR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        case (busy_op[i])
          BUSY_SET:   busy_q[i] <= 1'b1;
          BUSY_CLEAR: busy_q[i] <= 1'b0;
          default:    busy_q[i] <= busy_q[i];
        endcase
      end
    end
  end

  assign busy_vec_o = busy_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised integer register bank with a per-register busy scoreboard.
// Decode reads operands and reserves destinations; writeback writes results.
// Reads are combinational with optional same-cycle writeback forwarding.
// Ports:
//   clk, rst     - clock, synchronous active-high reset (clears data and busy)
//   wr_en_i      - writeback enable
//   rd_addr_i    - writeback destination
//   data_i       - writeback data
//   rs_addr_i    - packed read addresses, port k at [k*AW +: AW]
//   rs_data_o    - packed read data, port k at [k*XLEN +: XLEN]
//   rs_busy_o    - per read port: register has a pending write
//   rsv_en_i     - reserve rsv_addr_i as an in-flight destination
//   rsv_addr_i   - destination being reserved
//   rsv_ready_o  - reservation would be accepted this cycle
//   busy_vec_o   - full scoreboard
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NREAD    = NREAD_DEF,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = calc_aw(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         rd_addr_i,
  input  logic [XLEN-1:0]       data_i,
  input  logic [NREAD*AW-1:0]   rs_addr_i,
  output logic [NREAD*XLEN-1:0] rs_data_o,
  output logic [NREAD-1:0]      rs_busy_o,
  input  logic                  rsv_en_i,
  input  logic [AW-1:0]         rsv_addr_i,
  output logic                  rsv_ready_o,
  output logic [NREGS-1:0]      busy_vec_o
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_zero;
  logic [AW-1:0]   rs_addr [NREAD];
  logic            rs_zero [NREAD];
  logic            rs_hit  [NREAD];

  assign wr_zero = (ZERO_REG != 0) && (rd_addr_i == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++)
        regs_q[i] <= '0;
    end else if (wr_en_i && !wr_zero) begin
      regs_q[rd_addr_i] <= data_i;
    end
  end

  regfile_scoreboard_bits #(
    .NREGS    (NREGS),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_bits (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (wr_en_i),
    .rd_addr_i   (rd_addr_i),
    .rsv_en_i    (rsv_en_i),
    .rsv_addr_i  (rsv_addr_i),
    .rsv_ready_o (rsv_ready_o),
    .busy_vec_o  (busy_vec_o)
  );

  // Forwarding is held off during reset so reads show the array being
  // cleared rather than writeback data that will be discarded.
  always_comb begin
    rs_data_o = '0;
    rs_busy_o = '0;
    for (int unsigned k = 0; k < NREAD; k++) begin
      rs_addr[k] = rs_addr_i[port_lsb(k, AW) +: AW];
      rs_zero[k] = (ZERO_REG != 0) && (rs_addr[k] == '0);
      rs_hit[k]  = (BYPASS != 0) && !rst && wr_en_i && !rs_zero[k] &&
                   (rd_addr_i == rs_addr[k]);
      if (rs_zero[k]) begin
        rs_data_o[port_lsb(k, XLEN) +: XLEN] = '0;
        rs_busy_o[k] = 1'b0;
      end else if (rs_hit[k]) begin
        rs_data_o[port_lsb(k, XLEN) +: XLEN] = data_i;
        rs_busy_o[k] = 1'b0;
      end else begin
        rs_data_o[port_lsb(k, XLEN) +: XLEN] = regs_q[rs_addr[k]];
        rs_busy_o[k] = busy_vec_o[rs_addr[k]];
      end
    end
  end

endmodule
